// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: instruction fields and status coming in, datapath enables
// and the memory request going out. The control unit takes the master side;
// the datapath/memory model takes the slave side.
interface multicycle_control_unit_if #(
    parameter int ALU_CTRL_W = 3
);
    // Instruction fields and datapath/memory status
    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic                  zero;
    logic                  mem_ready;

    // Memory handshake
    logic                  mem_req;
    logic                  mem_we;
    logic                  iord;

    // Datapath enables and selects
    logic                  ir_we;
    logic                  pc_we;
    logic [1:0]            pc_src;
    logic                  reg_we;
    logic [1:0]            reg_dst;
    logic [1:0]            mem_to_reg;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [ALU_CTRL_W-1:0] alu_control;

    // Status flags
    logic                  instr_done;
    logic                  illegal_op;
    logic                  mem_fault;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_control,
               instr_done, illegal_op, mem_fault
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_control,
               instr_done, illegal_op, mem_fault
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit. Sequences each instruction through an FSM over
// several clocks and drives per-state datapath enables. Memory accesses use a
// req/ready handshake guarded by a wait-state timeout that parks the unit in
// an absorbing FAULT state. Outputs are decoded from the state, except ir_we,
// pc_we and instr_done, which in memory/branch states also depend on
// mem_ready/zero in the same cycle.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 3,
    parameter int TIMEOUT    = 15,  // max wait cycles per access, 0 = no timeout
    parameter int CNT_W      = 4    // must be wide enough to hold TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_control_unit_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_R_WB,
        S_EXEC_I,
        S_I_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_JR,
        S_FAULT
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    // ALU operation codes
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b000);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b001);
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b010);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b111);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = ALU_CTRL_W'(3'b011);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL = ALU_CTRL_W'(3'b100);

    // Datapath select encodings
    localparam logic [1:0] PC_SRC_ALU  = 2'b00;
    localparam logic [1:0] PC_SRC_BR   = 2'b01;
    localparam logic [1:0] PC_SRC_JMP  = 2'b10;
    localparam logic [1:0] PC_SRC_RS   = 2'b11;
    localparam logic [1:0] DST_RT      = 2'b00;
    localparam logic [1:0] DST_RD      = 2'b01;
    localparam logic [1:0] DST_R31     = 2'b10;
    localparam logic [1:0] WB_ALUOUT   = 2'b00;
    localparam logic [1:0] WB_MDR      = 2'b01;
    localparam logic [1:0] WB_PC       = 2'b10;
    localparam logic [1:0] SRC_B_RT    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_IMMSH = 2'b11;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam bit               TIMEOUT_EN  = (TIMEOUT != 0);

    // True for the R-type functions the ALU implements (JR handled separately)
    function automatic logic is_alu_funct(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL: return 1'b1;
            default:                                              return 1'b0;
        endcase
    endfunction

    // ALU operation for an R-type function code
    function automatic logic [ALU_CTRL_W-1:0] alu_for_funct(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            FN_SLL:  return ALU_SLL;
            FN_SRL:  return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   wait_cnt;
    logic               in_mem_state;
    logic               timed_out;

    logic                  mem_req;
    logic                  mem_we;
    logic                  iord;
    logic                  ir_we;
    logic                  pc_we;
    logic [1:0]            pc_src;
    logic                  reg_we;
    logic [1:0]            reg_dst;
    logic [1:0]            mem_to_reg;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  instr_done;
    logic                  illegal_op;

    // Every state that waits on mem_ready; the wait counter only runs here
    assign in_mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);

    // Access has waited TIMEOUT cycles already and memory is still not ready
    assign timed_out = TIMEOUT_EN && in_mem_state && !bus.mem_ready &&
                       (wait_cnt == TIMEOUT_CNT);

    // State register; async reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Wait counter: counts not-ready cycles of the current access. Any cycle
    // outside a memory state (or a completing cycle) clears it, so it always
    // starts at zero on entry to the next access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (in_mem_state && !bus.mem_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Next-state and per-state output decode
    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = PC_SRC_ALU;
        reg_we      = 1'b0;
        reg_dst     = DST_RT;
        mem_to_reg  = WB_ALUOUT;
        alu_src_a   = 1'b0;
        alu_src_b   = SRC_B_RT;
        alu_control = ALU_AND;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;

        unique case (state)
            S_FETCH: begin
                // PC + 4 computed while the instruction word is read
                mem_req     = 1'b1;
                alu_src_b   = SRC_B_FOUR;
                alu_control = ALU_ADD;
                if (bus.mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = S_DECODE;
                end else if (timed_out) begin
                    state_next = S_FAULT;
                end
            end

            S_DECODE: begin
                // Branch target computed speculatively into ALUOut
                alu_src_b   = SRC_B_IMMSH;
                alu_control = ALU_ADD;
                case (bus.opcode)
                    OP_RTYPE: begin
                        if (bus.funct == FN_JR) begin
                            state_next = S_JR;
                        end else if (is_alu_funct(bus.funct)) begin
                            state_next = S_EXEC_R;
                        end else begin
                            illegal_op = 1'b1;
                            state_next = S_FETCH;
                        end
                    end
                    OP_ADDI:       state_next = S_EXEC_I;
                    OP_LW, OP_SW:  state_next = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_next = S_BRANCH;
                    OP_JAL:        state_next = S_JAL;
                    default: begin
                        illegal_op = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end

            S_EXEC_R: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRC_B_RT;
                alu_control = alu_for_funct(bus.funct);
                state_next  = S_R_WB;
            end

            S_R_WB: begin
                reg_we     = 1'b1;
                reg_dst    = DST_RD;
                mem_to_reg = WB_ALUOUT;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end

            S_EXEC_I: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRC_B_IMM;
                alu_control = ALU_ADD;
                state_next  = S_I_WB;
            end

            S_I_WB: begin
                reg_we     = 1'b1;
                reg_dst    = DST_RT;
                mem_to_reg = WB_ALUOUT;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end

            S_MEM_ADDR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = SRC_B_IMM;
                alu_control = ALU_ADD;
                state_next  = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (timed_out) begin
                    state_next = S_FAULT;
                end
            end

            S_MEM_WB: begin
                reg_we     = 1'b1;
                reg_dst    = DST_RT;
                mem_to_reg = WB_MDR;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end

            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (bus.mem_ready) begin
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end else if (timed_out) begin
                    state_next = S_FAULT;
                end
            end

            S_BRANCH: begin
                // rs - rt; the ALU zero flag decides the PC write this cycle
                alu_src_a   = 1'b1;
                alu_src_b   = SRC_B_RT;
                alu_control = ALU_SUB;
                pc_src      = PC_SRC_BR;
                pc_we       = (bus.opcode == OP_BEQ) ? bus.zero : !bus.zero;
                instr_done  = 1'b1;
                state_next  = S_FETCH;
            end

            S_JAL: begin
                reg_we     = 1'b1;
                reg_dst    = DST_R31;
                mem_to_reg = WB_PC;
                pc_we      = 1'b1;
                pc_src     = PC_SRC_JMP;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end

            S_JR: begin
                pc_we      = 1'b1;
                pc_src     = PC_SRC_RS;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end

            S_FAULT: begin
                // Absorbing: everything stays off until rst_n
                state_next = S_FAULT;
            end

            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // While rst_n is low every output is forced off, so the mem_ready-gated
    // enables of FETCH cannot leak a write and mem_req only rises on release.
    assign bus.mem_req     = rst_n & mem_req;
    assign bus.mem_we      = rst_n & mem_we;
    assign bus.iord        = rst_n & iord;
    assign bus.ir_we       = rst_n & ir_we;
    assign bus.pc_we       = rst_n & pc_we;
    assign bus.pc_src      = rst_n ? pc_src : 2'b00;
    assign bus.reg_we      = rst_n & reg_we;
    assign bus.reg_dst     = rst_n ? reg_dst : 2'b00;
    assign bus.mem_to_reg  = rst_n ? mem_to_reg : 2'b00;
    assign bus.alu_src_a   = rst_n & alu_src_a;
    assign bus.alu_src_b   = rst_n ? alu_src_b : 2'b00;
    assign bus.alu_control = rst_n ? alu_control : '0;
    assign bus.instr_done  = rst_n & instr_done;
    assign bus.illegal_op  = rst_n & illegal_op;

    // Sticky fault: FAULT is absorbing and only the async reset leaves it
    assign bus.mem_fault   = (state == S_FAULT);

endmodule
